dmem_dump_ctrl: RTL and testbench
=================================

Name: dmem_dump_ctrl

Overview:
Sequencer and arbiter for the DataMemory port. It shares the single memory port between the CPU load/store path and a debug dump engine. On command, the dump engine walks a word range and streams {address, word} out over a valid/ready interface. This replaces hierarchical memory dumps in benches and exposes a dump path to hardware debug logic. It sits between the CPU datapath and DataMemory; the memory itself is unchanged.

Parameters:
SIZE, 1024, DataMemory depth in 32-bit words
OFFSET, 0, byte address of DataMemory word 0
AW, 32, address width (byte addresses)
DW, 32, data width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  one-cycle dump command
base_addr  in  AW  first byte address; bits[1:0] ignored (forced 0)
word_count  in  16  number of words to dump
cpu_req  in  1  CPU memory access this cycle
cpu_we  in  1  CPU write enable
cpu_addr  in  AW  CPU byte address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  read data returned to CPU (mem_rdata pass-through)
cpu_stall  out  1  CPU must hold PC and retry its access
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  AW  memory byte address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  combinational read data for mem_addr
dump_valid  out  1  dump_addr/dump_data valid
dump_ready  in  1  consumer accepts the current word
dump_addr  out  AW  byte address of the dumped word
dump_data  out  DW  dumped word, little-endian {b3,b2,b1,b0}
busy  out  1  dump in progress
done  out  1  one-cycle pulse when a dump completes
range_err  out  1  sticky: last command was truncated; cleared by the next accepted start

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0: dump_valid, busy, done, range_err, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata, dump_addr, dump_data. cpu_rdata follows mem_rdata.
- FSM states: IDLE, READ, HOLD, FIN.
- IDLE:
  - start=1: latch ptr=base_addr&~3 and rem=word_count; busy=1 next cycle.
  - Range clamp: end=OFFSET+4*SIZE. If ptr<OFFSET or ptr>=end, set rem=0 and range_err=1. If ptr+4*rem>end, set rem=(end-ptr)/4 and range_err=1.
  - rem=0 -> FIN; otherwise -> READ.
  - start while busy is ignored.
- READ (dump owns the port):
  - mem_en=1, mem_we=0, mem_addr=ptr.
  - On the clock edge: dump_data<=mem_rdata, dump_addr<=ptr, dump_valid<=1; -> HOLD.
  - In this state cpu_stall=cpu_req; the CPU access is not forwarded.
- HOLD:
  - The port returns to the CPU; dump_valid=1, and dump_addr/dump_data stay stable until a handshake.
  - On dump_valid&dump_ready: dump_valid<=0, ptr+=4, rem-=1. If rem was 1 -> FIN, else -> READ.
- FIN: done=1 for exactly one cycle, busy<=0, -> IDLE.
- Whenever the dump does not own the port: mem_en=cpu_req, mem_we=cpu_req&cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_stall=0. Zero added CPU latency.
- Throughput: at most 1 word per 2 cycles. dump_ready held high gives a total of 2N+2 cycles from start to done.
- Address arithmetic: AW-bit wrap is impossible after the clamp.
- RST asserted mid-dump: immediate abort, no done pulse, partial word discarded.

Optional Feature:
DMEM_DUMP_CPU_PRIO_EN
- Defined: in READ, cpu_req=1 wins. The CPU access is forwarded, cpu_stall=0, and the dump stays in READ and retries next cycle. No dump progress occurs while the CPU issues back-to-back requests.
- Undefined: the dump has priority in READ exactly as above; the CPU stalls at most 1 cycle per dumped word.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, READ, HOLD, FIN}
  - WORD_BYTES=4
  - function word_align(addr)
  - localparam MEM_END=OFFSET+4*SIZE
- One natural sub-module: dmem_port_mux. Purely combinational CPU/dump selection of mem_* and cpu_stall, driven by a grant signal from the FSM.

Test Plan:
- Reset, then start with base=0x0, count=4, ready=1, memory words 0x8,0x0,0x666,0x10: four beats (0x0,0x8),(0x4,0x0),(0x8,0x666),(0xC,0x10); done at cycle 10 after start; range_err=0.
- count=0: no dump_valid, done 2 cycles after start, busy low afterwards.
- base=0xFF8 (SIZE=1024, OFFSET=0), count=5: exactly 2 beats (0xFF8, 0xFFC), then done; range_err=1 until the next start.
- ready held 0 for 5 cycles on beat 1: dump_addr/dump_data stable, no second read; release ready -> resumes; total beats unchanged.
- CPU store 0x11F to 0x20 on the same cycle as a READ:
  - Without the macro: cpu_stall=1 for 1 cycle, then the write lands.
  - With DMEM_DUMP_CPU_PRIO_EN: cpu_stall=0, the write lands immediately, and the dump read is delayed 1 cycle.
  - In both cases the memory at 0x20 ends as 0x11F.
- RST pulse during HOLD of beat 2 of 4: all outputs 0 immediately, no done; a new start=0x0/count=1 then dumps correctly.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the DataMemory dump controller.
// Build option: DMEM_DUMP_CPU_PRIO_EN lets the CPU win the port in READ.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    FIN
  } state_e;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned DMEM_SIZE   = 1024;
  localparam int unsigned DMEM_OFFSET = 0;

  function automatic logic [63:0] word_align(
    input logic [63:0] addr
  );
    return addr & ~64'(WORD_BYTES - 1);
  endfunction

  function automatic logic [63:0] mem_end(
    input int unsigned offset,
    input int unsigned size
  );
    return 64'(offset) + 64'(WORD_BYTES) * 64'(size);
  endfunction

  localparam logic [63:0] MEM_END = mem_end(DMEM_OFFSET, DMEM_SIZE);

endpackage

// File: rtl/dmem_dump_ctrl_port_mux.sv
// DataMemory port selection between CPU and dump engine.
// Purely combinational; grant comes from the dump sequencer.
module dmem_port_mux #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          grant,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [AW-1:0] dump_ptr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_stall
);

  always_comb begin
    mem_en    = cpu_req;
    mem_we    = cpu_req & cpu_we;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    if (grant) begin
      mem_en    = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = dump_ptr;
      mem_wdata = '0;
      cpu_stall = cpu_req;
    end
  end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// DataMemory port arbiter plus range dump sequencer.
// Build option: DMEM_DUMP_CPU_PRIO_EN gives CPU requests priority in READ.
module dmem_dump_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned SIZE   = DMEM_SIZE,
  parameter int unsigned OFFSET = DMEM_OFFSET,
  parameter int          AW     = 32,
  parameter int          DW     = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [15:0]   word_count,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          busy,
  output logic          done,
  output logic          range_err
);

  localparam logic [63:0] OFF  = 64'(OFFSET);
  localparam logic [63:0] SPAN = mem_end(OFFSET, SIZE) - OFF;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [15:0]   rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          dv_q, dv_d;
  logic [AW-1:0] daddr_q, daddr_d;
  logic [DW-1:0] ddata_q, ddata_d;

  logic          grant;
  logic [63:0]   st_ptr, st_rel, st_len;
  logic [15:0]   st_rem;
  logic          st_err;

`ifdef DMEM_DUMP_CPU_PRIO_EN
  assign grant = (state_q == READ) && !cpu_req;
`else
  assign grant = (state_q == READ);
`endif

  // Offset-relative pointer: below-range addresses wrap huge and fail too.
  always_comb begin
    st_ptr = word_align(64'(base_addr));
    st_rel = st_ptr - OFF;
    st_len = 64'(word_count) << 2;
    st_rem = word_count;
    st_err = 1'b0;
    if (st_rel >= SPAN) begin
      st_rem = '0;
      st_err = 1'b1;
    end else if (st_rel + st_len > SPAN) begin
      st_rem = 16'((SPAN - st_rel) >> 2);
      st_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    dv_d    = dv_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = AW'(st_ptr);
          rem_d   = st_rem;
          err_d   = st_err;
          busy_d  = 1'b1;
          state_d = (st_rem == '0) ? FIN : READ;
        end
      end
      READ: begin
        if (grant) begin
          dv_d    = 1'b1;
          daddr_d = ptr_q;
          ddata_d = mem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (dv_q && dump_ready) begin
          dv_d    = 1'b0;
          ptr_d   = ptr_q + AW'(WORD_BYTES);
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? FIN : READ;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      daddr_q <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
    end
  end

  dmem_port_mux #(
    .AW(AW),
    .DW(DW)
  ) u_port_mux (
    .grant    (grant),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .dump_ptr (ptr_q),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall)
  );

  assign cpu_rdata  = mem_rdata;
  assign dump_valid = dv_q;
  assign dump_addr  = daddr_q;
  assign dump_data  = ddata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign range_err  = err_q;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Directed plus randomized bench for dmem_dump_ctrl.
// Reference: dump range computed from base/count with plain arithmetic.
module tb_dmem_dump_ctrl;

  localparam int SIZE   = 1024;
  localparam int OFFSET = 0;
  localparam int AW     = 32;
  localparam int DW     = 32;

`ifdef DMEM_DUMP_CPU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   word_count;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          dump_valid, dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          busy, done, range_err;

  always #5 CLK = ~CLK;

  dmem_dump_ctrl #(
    .SIZE(SIZE), .OFFSET(OFFSET), .AW(AW), .DW(DW)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .busy(busy), .done(done), .range_err(range_err)
  );

  logic [31:0] mem [0:SIZE-1];

  assign mem_rdata = (mem_addr < 32'(4 * SIZE)) ?
                     mem[mem_addr[11:2]] : '0;

  always @(posedge CLK)
    if (mem_en && mem_we && mem_addr < 32'(4 * SIZE))
      mem[mem_addr[11:2]] <= mem_wdata;

  logic [63:0] beats[$];
  logic [63:0] exp_q[$];
  bit          exp_err;
  int          done_cnt, dump_reads;
  int          checks, errors;
  bit          rand_ready, rand_cpu;

  always @(negedge CLK) begin
    if (dump_valid === 1'b1 && dump_ready === 1'b1)
      beats.push_back({dump_addr, dump_data});
    if (done === 1'b1) done_cnt++;
    if (mem_en && !mem_we && !cpu_req) dump_reads++;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected beats: clamp the word range into [OFFSET, OFFSET+4*SIZE).
  task automatic ref_dump(input logic [31:0] base, input int cnt);
    longint p, e;
    int     n;
    p = longint'(base & 32'hFFFF_FFFC);
    e = longint'(OFFSET) + 4 * longint'(SIZE);
    n = cnt;
    exp_err = 1'b0;
    exp_q.delete();
    if (p < OFFSET || p >= e) begin
      n = 0;
      exp_err = 1'b1;
    end else if (p + 4 * n > e) begin
      n = int'((e - p) / 4);
      exp_err = 1'b1;
    end
    for (int i = 0; i < n; i++)
      exp_q.push_back({32'(p + 4 * i),
                       mem[int'((p + 4 * i - OFFSET) / 4)]});
  endtask

  task automatic cmp_beats(input string tag);
    check({tag, "_n"}, 64'(beats.size()), 64'(exp_q.size()));
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), beats[i], exp_q[i]);
  endtask

  task automatic wait_done(inout int cyc);
    while (done !== 1'b1 && cyc < 400) begin
      if (rand_ready) dump_ready = 1'($urandom_range(0, 1));
      if (rand_cpu) begin
        cpu_req  = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 4 * SIZE - 1));
      end
      tick();
      cyc++;
    end
    check("done_seen", 64'(done), 64'd1);
    cpu_req    = 1'b0;
    dump_ready = 1'b1;
  endtask

  task automatic do_dump(input logic [31:0] base,
                         input int cnt,
                         output int cyc);
    ref_dump(base, cnt);
    beats.delete();
    done_cnt   = 0;
    base_addr  = base;
    word_count = 16'(cnt);
    start      = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    check("err_at_start", 64'(range_err), 64'(exp_err));
    check("busy_at_start", 64'(busy), 64'd1);
    wait_done(cyc);
    tick();
  endtask

  initial begin
    int          cyc, r0, stalls;
    bit          stable, s1, s2, dv2;
    logic [31:0] a0, d0, b;
    checks = 0; errors = 0;
    done_cnt = 0; dump_reads = 0;
    rand_ready = 0; rand_cpu = 0;
    for (int i = 0; i < SIZE; i++) mem[i] = '0;
    RST = 1'b1; start = 1'b0;
    base_addr = '0; word_count = '0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    dump_ready = 1'b1;
    mem[0] = 32'h8; mem[1] = 32'h0;
    mem[2] = 32'h666; mem[3] = 32'h10;
    tick(); tick();

    check("rst_flags", 64'({dump_valid, busy, done, range_err,
                            cpu_stall, mem_en, mem_we}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_dump_addr", 64'(dump_addr), 64'd0);
    check("rst_dump_data", 64'(dump_data), 64'd0);
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'(mem[0]));
    RST = 1'b0;
    tick();

    do_dump(32'h0, 4, cyc);
    check("t1_cycles", 64'(cyc), 64'd10);
    cmp_beats("t1");
    check("t1_err", 64'(range_err), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    do_dump(32'h0, 0, cyc);
    check("t2_cycles", 64'(cyc), 64'd2);
    cmp_beats("t2");
    check("t2_busy", 64'(busy), 64'd0);

    do_dump(32'hFF8, 5, cyc);
    cmp_beats("t3");
    tick(); tick();
    check("t3_err_sticky", 64'(range_err), 64'd1);

    ref_dump(32'h100, 3);
    beats.delete();
    dump_ready = 1'b0;
    base_addr  = 32'h100;
    word_count = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check("t4_err_clear", 64'(range_err), 64'd0);
    while (dump_valid !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("t4_valid", 64'(dump_valid), 64'd1);
    a0 = dump_addr; d0 = dump_data; r0 = dump_reads;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (dump_addr !== a0 || dump_data !== d0 ||
          dump_valid !== 1'b1) stable = 1'b0;
    end
    check("t4_stable", 64'(stable), 64'd1);
    check("t4_addr0", 64'(a0), 64'h100);
    check("t4_no_reread", 64'(dump_reads - r0), 64'd0);
    dump_ready = 1'b1;
    wait_done(cyc);
    tick();
    cmp_beats("t4");

    mem[8] = 32'h0;
    ref_dump(32'h40, 2);
    beats.delete();
    base_addr  = 32'h40;
    word_count = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h20; cpu_wdata = 32'h11F;
    #1 s1 = cpu_stall;
    tick();
    dv2 = dump_valid;
    if (!s1) cpu_req = 1'b0;
    #1 s2 = cpu_stall;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    stalls = int'(s1) + int'(s2);
    check("t5_stall_c1", 64'(s1), 64'(!PRIO));
    check("t5_stalls", 64'(stalls), PRIO ? 64'd0 : 64'd1);
    check("t5_valid_c2", 64'(dv2), 64'(!PRIO));
    check("t5_mem20", 64'(mem[8]), 64'h11F);
    cyc = 3;
    wait_done(cyc);
    tick();
    cmp_beats("t5");

    done_cnt = 0;
    dump_ready = 1'b0;
    base_addr  = 32'h0;
    word_count = 16'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (dump_valid !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    dump_ready = 1'b1;
    tick();
    dump_ready = 1'b0;
    tick();
    check("t6_beat2_hold", 64'(dump_valid), 64'd1);
    RST = 1'b1;
    #1;
    check("t6_rst_flags", 64'({dump_valid, busy, done, range_err,
                               cpu_stall, mem_en, mem_we}), 64'd0);
    check("t6_rst_daddr", 64'(dump_addr), 64'd0);
    check("t6_rst_ddata", 64'(dump_data), 64'd0);
    tick(); tick();
    RST = 1'b0;
    dump_ready = 1'b1;
    tick(); tick();
    check("t6_no_done", 64'(done_cnt), 64'd0);
    do_dump(32'h0, 1, cyc);
    check("t6_cycles", 64'(cyc), 64'd4);
    cmp_beats("t6");

    for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
    rand_ready = 1; rand_cpu = 1;
    cpu_we = 1'b0;
    for (int it = 0; it < 9; it++) begin
      case (it % 3)
        0: b = 32'($urandom_range(0, 4 * SIZE - 1));
        1: b = 32'(4 * SIZE - $urandom_range(0, 24));
        default: b = 32'($urandom_range(4 * SIZE, 4 * SIZE + 64));
      endcase
      do_dump(b, $urandom_range(0, 8), cyc);
      cmp_beats($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_err", it), 64'(range_err), 64'(exp_err));
      check($sformatf("rnd%0d_done", it), 64'(done_cnt), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
